// File: rtl/mem_pkg.sv
// Shared types and constants for the Mini SRC main-memory stage.
// Holds the FSM state encoding, the default address width and the wait-counter width.
package mem_pkg;

    localparam int DEFAULT_ADDR_W = 9;
    localparam int CNT_W          = 4;
    localparam int DATA_W         = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    // Everything captured from the datapath when a request is accepted.
    typedef struct packed {
        logic              is_write;
        logic              reject;
        logic [DATA_W-1:0] data;
    } mem_req_t;

    // True when any address bit above the array index is set.
    function automatic logic upper_bits_set(input logic [31:0] addr, input int addr_w);
        logic [31:0] mask;
        mask = ~((32'd1 << addr_w) - 32'd1);
        return |(addr & mask);
    endfunction

endpackage

// File: rtl/memory_unit_if.sv
// Bus between the datapath/control unit (master) and the memory stage (slave).
// Carries MAR/MDR values, the request strobes and the completion/status lines.
interface memory_unit_if;

    logic [31:0] mar_q;
    logic [31:0] mdr_q;
    logic        Read;
    logic        Write;
    logic [31:0] Mdatain;
    logic        mem_busy;
    logic        mem_done;
    logic        addr_fault;

    modport master (
        output mar_q, mdr_q, Read, Write,
        input  Mdatain, mem_busy, mem_done, addr_fault
    );

    modport slave (
        input  mar_q, mdr_q, Read, Write,
        output Mdatain, mem_busy, mem_done, addr_fault
    );

endinterface

// File: rtl/ram_array.sv
// Single-port synchronous RAM with registered read; contents are never reset.
// Read-during-write returns the previous contents of the addressed word.
module ram_array #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/memory_unit.sv
// Word-addressed main-memory stage: fixed wait states, then one read or write access.
// Optional MEM_FAULT_EN rejects addresses with bits above ADDR_W set (addr_fault with mem_done).
module memory_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int WAIT_CYCLES = 2
) (
    input logic          clock,
    input logic          clear,
    memory_unit_if.slave bus
);

    mem_state_t        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    mem_req_t          req_reg;
    logic [31:0]       mdatain_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              fault_reg;

    logic              addr_reject;
    logic              access_edge;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_dout;

`ifdef MEM_FAULT_EN
    assign addr_reject = upper_bits_set(bus.mar_q, ADDR_W);
`else
    // Upper address bits are deliberately ignored so the array wraps.
    logic unused_upper;
    assign unused_upper = upper_bits_set(bus.mar_q, ADDR_W);
    assign addr_reject  = 1'b0;
`endif

    assign access_edge = (state_reg == ACCESS) && (cnt_reg == '0);

    // clear must suppress a commit landing on the same edge.
    assign ram_we = access_edge && req_reg.is_write && !req_reg.reject && !clear;

    // The live MAR feeds the RAM while idle so the registered read already
    // targets the right word even with zero wait states.
    assign ram_addr = (state_reg == IDLE) ? bus.mar_q[ADDR_W-1:0] : addr_reg;

    ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .din   (req_reg.data),
        .dout  (ram_dout)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            req_reg     <= '0;
            mdatain_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            fault_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.Read || bus.Write) begin
                        addr_reg         <= bus.mar_q[ADDR_W-1:0];
                        req_reg.data     <= bus.mdr_q;
                        req_reg.is_write <= bus.Write;
                        req_reg.reject   <= addr_reject;
                        cnt_reg          <= CNT_W'(WAIT_CYCLES);
                        busy_reg         <= 1'b1;
                        state_reg        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else begin
                        if (!req_reg.is_write && !req_reg.reject) begin
                            mdatain_reg <= ram_dout;
                        end
                        done_reg  <= 1'b1;
                        fault_reg <= req_reg.reject;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.Mdatain    = mdatain_reg;
    assign bus.mem_busy   = busy_reg;
    assign bus.mem_done   = done_reg;
    assign bus.addr_fault = fault_reg;

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit: directed vector table, multi-cycle corner
// sequences and randomized transactions against a word-level reference model.
module tb_memory_unit;

    localparam int ADDR_W = 9;
    localparam int WAIT   = 2;

`ifdef MEM_FAULT_EN
    localparam bit          FLT = 1'b1;
    localparam logic [31:0] R6  = 32'h12345678;
    localparam logic [31:0] R8  = 32'h12345678;
`else
    localparam bit          FLT = 1'b0;
    localparam logic [31:0] R6  = 32'h0BADF00D;
    localparam logic [31:0] R8  = 32'hCAFEF00D;
`endif

    logic clk = 1'b0;
    logic clear;

    memory_unit_if bus ();

    memory_unit #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int txn_id      = 0;

    logic [31:0] mem_model [int];
    logic [31:0] exp_md;

    typedef struct {
        int          op;      // 0 read, 1 write, 2 read+write
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_md;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit model_reject(input logic [31:0] addr);
        return FLT && (addr[31:ADDR_W] != '0);
    endfunction

    // Update the reference memory for an accepted write.
    task automatic model_write(input int op, input logic [31:0] addr, input logic [31:0] data);
        if (op != 0 && !model_reject(addr)) begin
            mem_model[int'(addr[ADDR_W-1:0])] = data;
        end
    endtask

    // One request held until mem_done, then dropped; checks latency, busy and data.
    task automatic do_txn(input int op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] md, input logic flt);
        int lat;
        bit seen;
        lat  = 0;
        seen = 0;
        bus.mar_q = addr;
        bus.mdr_q = data;
        bus.Read  = (op == 0 || op == 2);
        bus.Write = (op != 0);
        while (!seen && lat < 40) begin
            tick();
            lat++;
            if (bus.mem_done === 1'b1) seen = 1;
            else chk("busy_wait", 32'(bus.mem_busy), 32'd1);
        end
        chk("done_latency", 32'(lat), 32'(WAIT + 2));
        chk("busy_at_done", 32'(bus.mem_busy), 32'd1);
        chk("addr_fault", 32'(bus.addr_fault), 32'(flt));
        chk("mdatain", bus.Mdatain, md);
        bus.Read  = 1'b0;
        bus.Write = 1'b0;
        tick();
        chk("done_width", 32'(bus.mem_done), 32'd0);
        chk("busy_release", 32'(bus.mem_busy), 32'd0);
        chk("fault_width", 32'(bus.addr_fault), 32'd0);
        chk("mdatain_hold", bus.Mdatain, md);
        $display("txn %0d op=%0d addr=%h data=%h mdatain=%h fault=%0b latency=%0d",
                 txn_id, op, addr, data, bus.Mdatain, bus.addr_fault, lat);
        txn_id++;
    endtask

    initial begin
        int dones;
        clear     = 1'b1;
        bus.mar_q = '0;
        bus.mdr_q = '0;
        bus.Read  = 1'b0;
        bus.Write = 1'b0;

        vecs[0] = '{1, 32'h005, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1] = '{0, 32'h005, 32'h00000000, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{2, 32'h007, 32'h12345678, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{0, 32'h007, 32'h00000000, 32'h12345678, 1'b0};
        vecs[4] = '{1, 32'h009, 32'hA5A5A5A5, 32'h12345678, 1'b0};
        vecs[5] = '{1, 32'h000, 32'h0BADF00D, 32'h12345678, 1'b0};
        vecs[6] = '{0, 32'h200, 32'h00000000, R6,           FLT};
        vecs[7] = '{1, 32'h203, 32'hCAFEF00D, R6,           FLT};
        vecs[8] = '{0, 32'h203, 32'h00000000, R8,           FLT};

        tick();
        tick();
        chk("reset_busy", 32'(bus.mem_busy), 32'd0);
        chk("reset_done", 32'(bus.mem_done), 32'd0);
        chk("reset_fault", 32'(bus.addr_fault), 32'd0);
        chk("reset_mdatain", bus.Mdatain, 32'd0);
        clear = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].exp_md, vecs[i].exp_fault);
            model_write(vecs[i].op, vecs[i].addr, vecs[i].data);
        end
        exp_md = vecs[8].exp_md;

        // clear one cycle into a write: nothing commits, outputs return to reset values
        bus.mar_q = 32'd9;
        bus.mdr_q = 32'hFFFFFFFF;
        bus.Write = 1'b1;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear     = 1'b0;
        bus.Write = 1'b0;
        chk("clear_busy", 32'(bus.mem_busy), 32'd0);
        chk("clear_done", 32'(bus.mem_done), 32'd0);
        chk("clear_mdatain", bus.Mdatain, 32'd0);
        exp_md = 32'd0;
        tick();
        chk("clear_stays_idle", 32'(bus.mem_busy), 32'd0);
        do_txn(0, 32'd9, 32'd0, 32'hA5A5A5A5, 1'b0);
        exp_md = 32'hA5A5A5A5;

        // clear coincident with a request: the request is not latched
        clear    = 1'b1;
        bus.Read = 1'b1;
        tick();
        clear    = 1'b0;
        bus.Read = 1'b0;
        tick();
        chk("clear_with_req_busy", 32'(bus.mem_busy), 32'd0);
        chk("clear_with_req_mdatain", bus.Mdatain, 32'd0);
        exp_md = 32'd0;

        // Read re-pulsed during ACCESS is ignored: exactly one completion
        bus.mar_q = 32'd5;
        bus.Read  = 1'b1;
        dones     = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.mem_done === 1'b1) dones++;
            bus.Read = (c == 1);
        end
        chk("repulse_done_count", 32'(dones), 32'd1);
        chk("repulse_mdatain", bus.Mdatain, 32'hDEADBEEF);

        // Read held through DONE starts a second back-to-back access
        bus.mar_q = 32'd7;
        bus.Read  = 1'b1;
        dones     = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.mem_done === 1'b1) dones++;
        end
        bus.Read = 1'b0;
        tick();
        tick();
        chk("b2b_done_count", 32'(dones), 32'd2);
        chk("b2b_mdatain", bus.Mdatain, 32'h12345678);
        chk("b2b_idle", 32'(bus.mem_busy), 32'd0);
        exp_md = 32'h12345678;

        // randomized transactions against the reference memory
        for (int n = 0; n < 40; n++) begin
            int          op;
            logic [31:0] addr;
            logic [31:0] data;
            bit          rej;
            op   = int'($urandom_range(0, 2));
            addr = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) addr = addr | (32'($urandom_range(1, 255)) << ADDR_W);
            data = $urandom;
            rej  = model_reject(addr);
            if (op == 0 && !rej && !mem_model.exists(int'(addr[ADDR_W-1:0]))) op = 1;
            if (op == 0 && !rej) exp_md = mem_model[int'(addr[ADDR_W-1:0])];
            do_txn(op, addr, data, exp_md, rej);
            model_write(op, addr, data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
